axi_write_response_queue: RTL

- Parametrised AXI4 slave B-channel generator for the CL abstraction layer. Successor to the single-response write-response block.
- Queues accepted AW IDs and completed W bursts independently, then pairs them in order.
- Issues one B response per pair, with the correct BID and per-burst BRESP (OKAY or a configurable error code).
- Holds each response stable under BREADY backpressure and supports back-to-back responses without bubbles.

---
 rtl/axi_resp_pkg.sv | 11 +
 rtl/write_response_fifo.sv | 60 ++++++
 rtl/axi_write_response_queue.sv | 116 +++++++++++
 3 files changed

// File: rtl/axi_resp_pkg.sv
// AXI response encodings shared by the write-response path.
package axi_resp_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/write_response_fifo.sv
// Synchronous FIFO with registered occupancy count; a push into a full queue
// is only accepted when the same edge pops.
module write_response_fifo #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         i_reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Pointer width equals log2(DEPTH), so plain increment wraps modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/axi_write_response_queue.sv
// AXI4 slave B-channel generator: pairs queued AW IDs with completed W bursts
// in order and presents one registered B response per pair.
module axi_write_response_queue
  import axi_resp_pkg::*;
#(
  parameter int unsigned ID_WIDTH = 4,
  parameter int unsigned DEPTH    = 8,
  parameter resp_t       ERR_RESP = RESP_SLVERR
) (
  input  logic                         clk,
  input  logic                         i_reset,
  input  logic                         i_aw_fire,
  input  logic [ID_WIDTH-1:0]          i_aw_id,
  input  logic                         i_wlast_fire,
  input  logic                         i_w_err,
  input  logic                         i_bready,
  output logic                         o_bvalid,
  output logic [ID_WIDTH-1:0]          o_bid,
  output resp_t                        o_bresp,
  output logic                         o_aw_ready,
  output logic                         o_w_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_pending,
  output logic                         o_overflow
);

  localparam int unsigned CntW = $clog2(DEPTH+1);

  logic [ID_WIDTH-1:0] aw_head;
  logic                aw_empty, aw_full;
  logic [CntW-1:0]     aw_count;
  logic                w_head;
  logic                w_empty, w_full;
  logic [CntW-1:0]     w_count;
  logic                unused_w_count;

  logic                pop;
  logic                bvalid_q, bvalid_d;
  logic [ID_WIDTH-1:0] bid_q, bid_d;
  resp_t               bresp_q, bresp_d;
  logic                overflow_q, overflow_d;

  write_response_fifo #(
    .WIDTH (ID_WIDTH),
    .DEPTH (DEPTH)
  ) u_aw_fifo (
    .clk       (clk),
    .i_reset   (i_reset),
    .push      (i_aw_fire),
    .push_data (i_aw_id),
    .pop       (pop),
    .head      (aw_head),
    .empty     (aw_empty),
    .full      (aw_full),
    .count     (aw_count)
  );

  write_response_fifo #(
    .WIDTH (1),
    .DEPTH (DEPTH)
  ) u_w_fifo (
    .clk       (clk),
    .i_reset   (i_reset),
    .push      (i_wlast_fire),
    .push_data (i_w_err),
    .pop       (pop),
    .head      (w_head),
    .empty     (w_empty),
    .full      (w_full),
    .count     (w_count)
  );

  assign unused_w_count = ^w_count;

  // The output slot is free when empty or being drained this cycle.
  assign pop = !aw_empty && !w_empty && (!bvalid_q || i_bready);

  always_comb begin
    bvalid_d   = bvalid_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    overflow_d = overflow_q;
    if (pop) begin
      bvalid_d = 1'b1;
      bid_d    = aw_head;
      bresp_d  = w_head ? ERR_RESP : RESP_OKAY;
    end else if (bvalid_q && i_bready) begin
      bvalid_d = 1'b0;
    end
    if ((i_aw_fire && aw_full && !pop) || (i_wlast_fire && w_full && !pop)) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= RESP_OKAY;
      overflow_q <= 1'b0;
    end else begin
      bvalid_q   <= bvalid_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
      overflow_q <= overflow_d;
    end
  end

  assign o_bvalid   = bvalid_q;
  assign o_bid      = bid_q;
  assign o_bresp    = bresp_q;
  assign o_overflow = overflow_q;
  assign o_aw_ready = !aw_full;
  assign o_w_ready  = !w_full;
  assign o_pending  = aw_count + CntW'(bvalid_q);

endmodule
